// File: rtl/adler32_stream_if.sv
// Handshake bundle for the streaming Adler-32 engine: a framed byte-beat input
// channel and a single-slot checksum result channel.
interface adler32_stream_if #(
  parameter int BYTES_PER_BEAT = 1
);
  logic                          in_valid;
  logic                          in_ready;
  logic [8*BYTES_PER_BEAT-1:0]   in_data;
  logic [BYTES_PER_BEAT-1:0]     in_keep;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [31:0]                   out_checksum;
  logic [31:0]                   out_len;

  modport master (
    output in_valid, in_data, in_keep, in_last, out_ready,
    input  in_ready, out_valid, out_checksum, out_len
  );

  modport slave (
    input  in_valid, in_data, in_keep, in_last, out_ready,
    output in_ready, out_valid, out_checksum, out_len
  );
endinterface

// File: rtl/adler32_stream.sv
// Streaming Adler-32 engine: folds up to BYTES_PER_BEAT bytes per accepted beat
// into running A/B sums and emits {B,A} plus the byte count once per frame.
module adler32_stream #(
  parameter int BYTES_PER_BEAT = 1,
  parameter int MOD            = 65521
) (
  input logic              clk,
  input logic              rst_n,
  adler32_stream_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [16:0] MOD17 = 17'(MOD);

  state_t      state_q;
  logic [15:0] sumA_q, sumB_q;
  logic [31:0] len_q;
  logic        outValid_q;
  logic [31:0] outChecksum_q, outLen_q;

  logic [15:0] sumA_d, sumB_d;
  logic [31:0] len_d;
  logic [16:0] stepA, stepB;
  logic        inFire, outFire;

  // A beat can enter whenever the single result slot is empty or being drained.
  assign bus.in_ready     = rst_n & (~outValid_q | bus.out_ready);
  assign inFire           = bus.in_valid & bus.in_ready;
  assign outFire          = outValid_q & bus.out_ready;
  assign bus.out_valid    = outValid_q;
  assign bus.out_checksum = outChecksum_q;
  assign bus.out_len      = outLen_q;

  always_comb begin
    sumA_d = sumA_q;
    sumB_d = sumB_q;
    len_d  = len_q;
    stepA  = '0;
    stepB  = '0;
    // One 17-bit add and a single conditional subtract per byte keeps A,B < MOD.
    for (int k = 0; k < BYTES_PER_BEAT; k++) begin
      if (bus.in_keep[k]) begin
        stepA = {1'b0, sumA_d} + {9'd0, bus.in_data[8*k +: 8]};
        if (stepA >= MOD17) stepA = stepA - MOD17;
        sumA_d = stepA[15:0];
        stepB = {1'b0, sumB_d} + {1'b0, sumA_d};
        if (stepB >= MOD17) stepB = stepB - MOD17;
        sumB_d = stepB[15:0];
        len_d  = len_d + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sumA_q        <= 16'd1;
      sumB_q        <= 16'd0;
      len_q         <= 32'd0;
      outValid_q    <= 1'b0;
      outChecksum_q <= 32'd0;
      outLen_q      <= 32'd0;
    end else begin
      if (outFire) outValid_q <= 1'b0;
      if (inFire) begin
        if (bus.in_last) begin
          outChecksum_q <= {sumB_d, sumA_d};
          outLen_q      <= len_d;
          outValid_q    <= 1'b1;
          sumA_q        <= 16'd1;
          sumB_q        <= 16'd0;
          len_q         <= 32'd0;
        end else begin
          sumA_q <= sumA_d;
          sumB_q <= sumB_d;
          len_q  <= len_d;
        end
        // Frame-in-progress tracking only; it never gates the datapath.
        case (state_q)
          IDLE:    if (!bus.in_last) state_q <= BUSY;
          BUSY:    if (bus.in_last)  state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  function automatic logic keepContiguous(input logic [BYTES_PER_BEAT-1:0] keep);
    logic [BYTES_PER_BEAT-1:0] plusOne;
    plusOne = keep + BYTES_PER_BEAT'(1);
    return (keep & plusOne) == '0;
  endfunction

  keepOk: assert property (@(posedge clk) disable iff (!rst_n)
                           inFire |-> keepContiguous(bus.in_keep))
    else $error("adler32_stream: non-contiguous in_keep");

endmodule

// File: tb/tb_adler32_stream.sv
// Bench for adler32_stream: one BPB=1 and one BPB=4 instance, directed vectors
// plus randomized frames and back-pressure against a plain-arithmetic model.
module tb_adler32_stream;

  typedef byte unsigned byteQ_t[$];
  typedef struct {
    logic [31:0] ck;
    logic [31:0] len;
  } result_t;

  logic clk;
  logic rst_n;
  logic outReadyDrv;
  int   holdCycles;
  bit   randomBp;
  int   testsRun;
  int   testsFailed;
  int   heldCount4;

  result_t exp1[$];
  result_t exp4[$];

  adler32_stream_if #(.BYTES_PER_BEAT(1)) bus1();
  adler32_stream_if #(.BYTES_PER_BEAT(4)) bus4();

  adler32_stream #(.BYTES_PER_BEAT(1), .MOD(65521)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  adler32_stream #(.BYTES_PER_BEAT(4), .MOD(65521)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  assign bus1.out_ready = outReadyDrv;
  assign bus4.out_ready = outReadyDrv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference Adler-32 straight from the definition, using the % operator.
  function automatic logic [31:0] refAdler(input byteQ_t d);
    int unsigned a, b;
    a = 1;
    b = 0;
    foreach (d[i]) begin
      a = (a + d[i]) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  task automatic makeBytes(input string s, output byteQ_t q);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  // out_ready changes just after the rising edge so it is stable at the falling edge.
  always @(posedge clk) begin
    #1;
    if (holdCycles > 0) begin
      outReadyDrv = 1'b0;
      holdCycles--;
    end else if (randomBp) begin
      outReadyDrv = ($urandom_range(0, 3) != 0);
    end else begin
      outReadyDrv = 1'b1;
    end
  end

  logic        held1, held4;
  logic [31:0] heldCk1, heldLen1, heldCk4, heldLen4;

  always @(negedge clk) begin
    if (!rst_n) begin
      held1 = 1'b0;
    end else begin
      if (held1) begin
        checkOutput("holdValid1", 32'(bus1.out_valid), 32'd1);
        checkOutput("holdCk1", bus1.out_checksum, heldCk1);
        checkOutput("holdLen1", bus1.out_len, heldLen1);
      end
      held1 = bus1.out_valid && !bus1.out_ready;
      if (held1) begin
        checkOutput("inReadyHeld1", 32'(bus1.in_ready), 32'd0);
        heldCk1  = bus1.out_checksum;
        heldLen1 = bus1.out_len;
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (exp1.size() == 0) begin
          checkOutput("unexpectedResult1", 32'd1, 32'd0);
        end else begin
          result_t r;
          r = exp1.pop_front();
          checkOutput("checksum1", bus1.out_checksum, r.ck);
          checkOutput("len1", bus1.out_len, r.len);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held4 = 1'b0;
    end else begin
      if (held4) begin
        checkOutput("holdValid4", 32'(bus4.out_valid), 32'd1);
        checkOutput("holdCk4", bus4.out_checksum, heldCk4);
        checkOutput("holdLen4", bus4.out_len, heldLen4);
      end
      held4 = bus4.out_valid && !bus4.out_ready;
      if (held4) begin
        checkOutput("inReadyHeld4", 32'(bus4.in_ready), 32'd0);
        heldCk4  = bus4.out_checksum;
        heldLen4 = bus4.out_len;
        heldCount4++;
      end
      if (bus4.out_valid && bus4.out_ready) begin
        if (exp4.size() == 0) begin
          checkOutput("unexpectedResult4", 32'd1, 32'd0);
        end else begin
          result_t r;
          r = exp4.pop_front();
          checkOutput("checksum4", bus4.out_checksum, r.ck);
          checkOutput("len4", bus4.out_len, r.len);
        end
      end
    end
  end

  // Drives one beat at the falling edge and holds it until the engine takes it.
  task automatic applyStimulus(input int bpb, input logic [31:0] data, input logic [3:0] keep,
                               input bit last, output bit ok);
    int waited;
    @(negedge clk);
    if (bpb == 1) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = data[7:0];
      bus1.in_keep  = keep[0];
      bus1.in_last  = last;
    end else begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = data;
      bus4.in_keep  = keep;
      bus4.in_last  = last;
    end
    waited = 0;
    while ((((bpb == 1) ? bus1.in_ready : bus4.in_ready) !== 1'b1) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    ok = (waited < 200);
    if (!ok) begin
      checkOutput("inReadyTimeout", 32'(waited), 32'd0);
    end else begin
      @(posedge clk);
      #1;
    end
    bus1.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
  endtask

  task automatic sendFrame(input int bpb, input byteQ_t bytes, input bit randomKeep, input logic [31:0] expCk);
    int          idx, rem, maxN, n;
    bit          ok, last;
    logic [31:0] data;
    logic [3:0]  keep;
    result_t     r;
    idx = 0;
    do begin
      rem  = bytes.size() - idx;
      maxN = (rem < bpb) ? rem : bpb;
      n    = randomKeep ? int'($urandom_range(0, maxN)) : maxN;
      data = $urandom();
      for (int k = 0; k < n; k++) data[8*k +: 8] = bytes[idx + k];
      keep = 4'((1 << n) - 1);
      idx += n;
      last = (idx == bytes.size());
      applyStimulus(bpb, data, keep, last, ok);
      if (ok && last) begin
        r.ck  = expCk;
        r.len = 32'(bytes.size());
        if (bpb == 1) exp1.push_back(r);
        else          exp4.push_back(r);
      end
    end while (!last && ok);
  endtask

  task automatic waitDrain();
    int waited;
    waited = 0;
    while ((exp1.size() != 0 || exp4.size() != 0) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drainPending", 32'(exp1.size() + exp4.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failed so far", testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byteQ_t q;
    bit     ok;
    testsRun    = 0;
    testsFailed = 0;
    heldCount4  = 0;
    holdCycles  = 0;
    randomBp    = 1'b0;
    outReadyDrv = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_keep = '0; bus1.in_last = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_keep = '0; bus4.in_last = 1'b0;
    rst_n = 1'b0;

    #12;
    checkOutput("rstInReady1", 32'(bus1.in_ready), 32'd0);
    checkOutput("rstInReady4", 32'(bus4.in_ready), 32'd0);
    checkOutput("rstOutValid1", 32'(bus1.out_valid), 32'd0);
    checkOutput("rstOutValid4", 32'(bus4.out_valid), 32'd0);
    checkOutput("rstChecksum4", bus4.out_checksum, 32'd0);
    checkOutput("rstLen4", bus4.out_len, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    makeBytes("a", q);
    sendFrame(1, q, 1'b0, 32'h0062_0062);
    makeBytes("abc", q);
    sendFrame(4, q, 1'b0, 32'h024D_0127);
    makeBytes("Wikipedia", q);
    sendFrame(4, q, 1'b0, 32'h11E6_0398);
    waitDrain();

    q = {};
    for (int i = 0; i < 1024; i++) q.push_back(8'hFF);
    sendFrame(1, q, 1'b0, 32'h79A6_FC2E);
    sendFrame(4, q, 1'b0, 32'h79A6_FC2E);
    waitDrain();

    q = {};
    sendFrame(1, q, 1'b0, 32'h0000_0001);
    sendFrame(4, q, 1'b0, 32'h0000_0001);
    makeBytes("a", q);
    sendFrame(1, q, 1'b0, 32'h0062_0062);
    sendFrame(4, q, 1'b0, 32'h0062_0062);
    waitDrain();

    // Back-to-back frames with the first result held off for several cycles.
    @(negedge clk);
    heldCount4 = 0;
    holdCycles = 7;
    makeBytes("a", q);
    sendFrame(4, q, 1'b0, 32'h0062_0062);
    makeBytes("Wikipedia", q);
    sendFrame(4, q, 1'b0, 32'h11E6_0398);
    waitDrain();
    checkOutput("heldAtLeast5", 32'(heldCount4 >= 5), 32'd1);

    // Reset while one engine holds a result and the other is mid-frame.
    @(negedge clk);
    holdCycles = 40;
    makeBytes("xyz", q);
    sendFrame(4, q, 1'b0, refAdler(q));
    applyStimulus(1, 32'h0000_0041, 4'b0001, 1'b0, ok);
    @(negedge clk);
    rst_n = 1'b0;
    exp1.delete();
    exp4.delete();
    #1;
    checkOutput("midRstOutValid4", 32'(bus4.out_valid), 32'd0);
    checkOutput("midRstOutValid1", 32'(bus1.out_valid), 32'd0);
    checkOutput("midRstInReady4", 32'(bus4.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    holdCycles = 0;
    makeBytes("a", q);
    sendFrame(1, q, 1'b0, 32'h0062_0062);
    sendFrame(4, q, 1'b0, 32'h0062_0062);
    waitDrain();

    // Randomized frames, partial keeps and random back-pressure.
    randomBp = 1'b1;
    for (int f = 0; f < 30; f++) begin
      for (int w = 0; w < 2; w++) begin
        int len;
        len = int'($urandom_range(0, 40));
        q = {};
        for (int i = 0; i < len; i++) q.push_back(8'($urandom()));
        sendFrame((w == 0) ? 1 : 4, q, 1'b1, refAdler(q));
      end
    end
    randomBp = 1'b0;
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
